// File: rtl/ct_f_spsram_pkg.sv
// ct_f_spsram_pkg: shared types and parameter limits for the parametrised single-port SRAM wrapper
package ct_f_spsram_pkg;
   typedef enum logic [1:0] {RST, CLR, RDY} fsm_t;
   localparam int MAX_DATA_WIDTH = 256;
   localparam int MAX_ADDR_WIDTH = 20;
endpackage

// File: rtl/ct_f_spsram_array.sv
// ct_f_spsram_array: 2^ADDR_WIDTH x DATA_WIDTH array with per-bit write enable and synchronous read flop
module ct_f_spsram_array #(
   parameter int DATA_WIDTH = 7,
   parameter int ADDR_WIDTH = 9
) (
   input  logic                  CLK,
   input  logic                  cpurst_b,
   input  logic                  we,
   input  logic [DATA_WIDTH-1:0] bit_en,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout
);
   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
   always_ff @(posedge CLK)
      if (we)
         for (int i = 0; i < DATA_WIDTH; i++)
            if (bit_en[i]) mem[addr][i] <= din[i];
   // The read flop only loads on an accepted read, which gives the output-hold behaviour
   always_ff @(posedge CLK or negedge cpurst_b)
      if (!cpurst_b) dout <= '0;
      else if (re) dout <= mem[addr];
endmodule

// File: rtl/ct_f_spsram_param.sv
// ct_f_spsram_param: parametrised FPGA single-port SRAM wrapper with ASIC-style CEN/GWEN/WEN ports
// CT_F_SPSRAM_INIT_EN compiles in the post-reset clear sweep; otherwise READY rises one clock after reset.
module ct_f_spsram_param
   import ct_f_spsram_pkg::*;
#(
   parameter int                    DATA_WIDTH = 7,
   parameter int                    ADDR_WIDTH = 9,
   parameter int                    OUT_REG    = 0,
   parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
   input  logic                  CLK,
   input  logic                  cpurst_b,
   input  logic                  CEN,
   input  logic                  GWEN,
   input  logic [DATA_WIDTH-1:0] WEN,
   input  logic [ADDR_WIDTH-1:0] A,
   input  logic [DATA_WIDTH-1:0] D,
   output logic [DATA_WIDTH-1:0] Q,
   output logic                  READY
);
   if (DATA_WIDTH < 1 || DATA_WIDTH > MAX_DATA_WIDTH || $bits(INIT_VAL) != DATA_WIDTH) begin : g_bad_dw
      $error("ct_f_spsram_param: DATA_WIDTH out of range");
   end
   if (ADDR_WIDTH < 1 || ADDR_WIDTH > MAX_ADDR_WIDTH) begin : g_bad_aw
      $error("ct_f_spsram_param: ADDR_WIDTH out of range");
   end

   logic                  ready;
   logic                  sweep;
   logic                  acc;
   logic                  we;
   logic                  re;
   logic [DATA_WIDTH-1:0] bit_en;
   logic [DATA_WIDTH-1:0] din;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] q1;

`ifdef CT_F_SPSRAM_INIT_EN
   fsm_t                  state;
   fsm_t                  state_nxt;
   logic [ADDR_WIDTH-1:0] cnt;
   always_ff @(posedge CLK or negedge cpurst_b)
      if (!cpurst_b) state <= RST;
      else state <= state_nxt;
   always_comb
      state_nxt = (state == RST) ? CLR : (state == CLR && cnt == '1) ? RDY : state;
   always_comb begin
      sweep = state == CLR;
      ready = state == RDY;
   end
   // The counter parks at its maximum so the sweep never wraps into a second pass
   always_ff @(posedge CLK or negedge cpurst_b)
      if (!cpurst_b) cnt <= '0;
      else if (sweep && cnt != '1) cnt <= cnt + ADDR_WIDTH'(1);
   always_comb begin
      addr   = sweep ? cnt : A;
      din    = sweep ? INIT_VAL : D;
      bit_en = sweep ? '1 : ~WEN;
   end
`else
   always_ff @(posedge CLK or negedge cpurst_b)
      if (!cpurst_b) ready <= 1'b0;
      else ready <= 1'b1;
   always_comb begin
      sweep  = 1'b0;
      addr   = A;
      din    = D;
      bit_en = ~WEN;
   end
`endif

   always_comb begin
      acc = ready & ~CEN;
      we  = sweep | (acc & ~GWEN);
      re  = acc & GWEN;
   end

   ct_f_spsram_array #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_array (
      .CLK(CLK),
      .cpurst_b(cpurst_b),
      .we(we),
      .bit_en(bit_en),
      .re(re),
      .addr(addr),
      .din(din),
      .dout(q1)
   );

   if (OUT_REG != 0) begin : g_oreg
      logic [DATA_WIDTH-1:0] q2;
      always_ff @(posedge CLK or negedge cpurst_b)
         if (!cpurst_b) q2 <= '0;
         else q2 <= q1;
      assign Q = q2;
   end else begin : g_nreg
      assign Q = q1;
   end

   assign READY = ready;
endmodule

// File: tb/tb_ct_f_spsram_param.sv
// tb_ct_f_spsram_param: scoreboard bench driving OUT_REG=0 and OUT_REG=1 instances with shared stimulus
module tb_ct_f_spsram_param;
   localparam int DW = 7;
   localparam int AW = 4;
   localparam logic [DW-1:0] IV = 7'h55;
`ifdef CT_F_SPSRAM_INIT_EN
   localparam int RDY_LAT = 17;
   localparam logic [DW-1:0] A2_AFTER_RST = IV;
`else
   localparam int RDY_LAT = 1;
   localparam logic [DW-1:0] A2_AFTER_RST = 7'h22;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic cen = 1'b1;
   logic gwen = 1'b1;
   logic [DW-1:0] wen = '1;
   logic [DW-1:0] d = '0;
   logic [AW-1:0] a = '0;
   logic [DW-1:0] q0, q1;
   logic rdy0, rdy1;
   int checks = 0;
   int failures = 0;
   logic [DW-1:0] exp0[$];
   logic [DW-1:0] exp1[$];
   logic v0 = 1'b0, v1a = 1'b0, v1b = 1'b0;

   always #5 clk = ~clk;

   ct_f_spsram_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_REG(0), .INIT_VAL(IV)) u0 (
      .CLK(clk), .cpurst_b(rst_n), .CEN(cen), .GWEN(gwen), .WEN(wen), .A(a), .D(d), .Q(q0), .READY(rdy0));
   ct_f_spsram_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_REG(1), .INIT_VAL(IV)) u1 (
      .CLK(clk), .cpurst_b(rst_n), .CEN(cen), .GWEN(gwen), .WEN(wen), .A(a), .D(d), .Q(q1), .READY(rdy1));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: a read seen at the negedge before an edge is due 1 (OUT_REG=0) or 2 (OUT_REG=1) edges later
   initial forever begin
      @(negedge clk);
      if (v0) begin
         if (exp0.size() == 0) begin
            checks++; failures++;
            $display("FAIL q0_underflow: got %0h expected none", q0);
         end else chk("q0_read", q0, exp0.pop_front());
      end
      if (v1b) begin
         if (exp1.size() == 0) begin
            checks++; failures++;
            $display("FAIL q1_underflow: got %0h expected none", q1);
         end else chk("q1_read", q1, exp1.pop_front());
      end
      v1b = v1a;
      v1a = rdy1 & ~cen & gwen;
      v0  = rdy0 & ~cen & gwen;
   end

   task automatic cyc(input logic c, input logic g, input logic [DW-1:0] w, input logic [DW-1:0] dd, input logic [AW-1:0] aa);
      cen = c; gwen = g; wen = w; d = dd; a = aa;
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [AW-1:0] aa, input logic [DW-1:0] dd, input logic [DW-1:0] w);
      cyc(1'b0, 1'b0, w, dd, aa);
   endtask

   task automatic rd(input logic [AW-1:0] aa, input logic [DW-1:0] e);
      exp0.push_back(e);
      exp1.push_back(e);
      cyc(1'b0, 1'b1, '1, '0, aa);
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(1'b1, 1'b1, '1, '0, a);
   endtask

   task automatic wait_ready(input string nm);
      int n = 0;
      while (!rdy0 && n < 60) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk(nm, n, RDY_LAT);
      chk({nm, "_u1"}, {31'd0, rdy1}, 1);
   endtask

   task automatic chk_reset(input string nm);
      chk({nm, "_q0"}, q0, 0);
      chk({nm, "_q1"}, q1, 0);
      chk({nm, "_rdy0"}, {31'd0, rdy0}, 0);
      chk({nm, "_rdy1"}, {31'd0, rdy1}, 0);
   endtask

   initial begin
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset("reset");
      rst_n = 1'b1;
      wait_ready("ready_lat");
`ifdef CT_F_SPSRAM_INIT_EN
      for (int i = 0; i < 16; i++) rd(AW'(i), IV);
`endif
      wr(4'd3, 7'h7F, 7'h00);
      wr(4'd3, 7'h00, 7'b1110000);
      rd(4'd3, 7'h70);
      wr(4'd5, 7'h2A, 7'h00);
      wr(4'd1, 7'h11, 7'h00);
      wr(4'd2, 7'h22, 7'h00);
      wr(4'd3, 7'h33, 7'h00);
      rd(4'd1, 7'h11);
      rd(4'd2, 7'h22);
      rd(4'd3, 7'h33);
      idle(2);
      chk("hold_q0", q0, 7'h33);
      chk("hold_q1", q1, 7'h33);
      cyc(1'b0, 1'b0, '1, 7'h00, 4'd3);
      idle(2);
      chk("noop_q0", q0, 7'h33);
      chk("noop_q1", q1, 7'h33);
      rd(4'd3, 7'h33);
      rd(4'd5, 7'h2A);
      for (int i = 0; i < 10; i++) begin
         cyc(1'b1, i[0], '0, 7'(i * 13), AW'(i));
         chk("idle_q0", q0, 7'h2A);
         chk("idle_q1", q1, 7'h2A);
      end
      rd(4'd1, 7'h11);
      rd(4'd3, 7'h33);
      rd(4'd5, 7'h2A);
      idle(3);
      rst_n = 1'b0;
      #1;
      chk_reset("midop_reset");
      cyc(1'b0, 1'b0, '0, 7'h01, 4'd2);
      cyc(1'b0, 1'b0, '0, 7'h01, 4'd2);
      idle(1);
      rst_n = 1'b1;
`ifdef CT_F_SPSRAM_INIT_EN
      repeat (9) cyc(1'b0, 1'b0, '0, 7'h01, 4'd2);
      chk("sweep_busy", {31'd0, rdy0}, 0);
      rst_n = 1'b0;
      #1;
      chk_reset("midsweep_reset");
      idle(1);
      rst_n = 1'b1;
`endif
      wait_ready("ready_lat2");
      rd(4'd2, A2_AFTER_RST);
`ifdef CT_F_SPSRAM_INIT_EN
      rd(4'd7, IV);
      rd(4'd15, IV);
`endif
      idle(4);
      chk("drain_q0", exp0.size(), 0);
      chk("drain_q1", exp1.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
